dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path, port 1 is the program/data loader (DMA).
- Performs round-robin arbitration with a req/gnt handshake and keeps at most one read outstanding.
- Returns read data with a fixed, parameterised memory latency.
- Sits between the core's memory-access logic and the data memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 29 ++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } arb_state_t;

    localparam int PORT_CPU   = 0;
    localparam int PORT_LDR   = 1;

    localparam int MAX_RD_LAT = 4;
    // lat_cnt only ever holds RD_LAT-1, so MAX_RD_LAT-1 must fit
    localparam int LAT_CNT_W  = $clog2(MAX_RD_LAT);

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side bundle of the data-memory arbiter
//
// Signals:
//   r0_* / r1_*  : requester ports (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*        : single-port data memory strobe, write enable, address, data
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory's view
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin picker
//
// Ports:
//   req[1:0]  in   pending requests, indexed by port
//   last_gnt  in   index of the most recent winner (held by the parent)
//   en        in   picking allowed this cycle
//   gnt[1:0]  out  one-hot grant, all zero when en=0 or no request
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // On a tie the port that did not win last time goes first
            if (req[PORT_CPU] && (!req[PORT_LDR] || last_gnt == 1'b1)) begin
                gnt[PORT_CPU] = 1'b1;
            end else if (req[PORT_LDR]) begin
                gnt[PORT_LDR] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of the data memory between CPU and loader
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of dmem_arbiter_if (requester ports 0/1 and memory side)
// Parameters:
//   ADDR_W, DATA_W  bus widths
//   RD_LAT          memory read latency in cycles, 1..MAX_RD_LAT
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    arb_state_t           state;
    logic                 last_gnt;
    logic                 owner;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic [1:0]           req;
    logic [1:0]           gnt;
    logic                 pick_en;
    logic                 granted;
    logic                 sel_ldr;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 rd_issue;

    logic                 r0_rvalid_q;
    logic                 r1_rvalid_q;
    logic [DATA_W-1:0]    r0_rdata_q;
    logic [DATA_W-1:0]    r1_rdata_q;

    assign req     = {bus.r1_req, bus.r0_req};
    // RD_RESP accepts new work like IDLE; only the wait for read data blocks
    assign pick_en = !rst && (state != RD_WAIT);

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_gnt (last_gnt),
        .en       (pick_en),
        .gnt      (gnt)
    );

    assign granted = |gnt;
    assign sel_ldr = gnt[PORT_LDR];

    // Winner's qualifiers; everything stays zero when nobody is granted
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[PORT_LDR]) begin
            sel_we    = bus.r1_we;
            sel_addr  = bus.r1_addr;
            sel_wdata = bus.r1_wdata;
        end else if (gnt[PORT_CPU]) begin
            sel_we    = bus.r0_we;
            sel_addr  = bus.r0_addr;
            sel_wdata = bus.r0_wdata;
        end
    end

    assign rd_issue      = granted && !sel_we;

    assign bus.r0_gnt    = gnt[PORT_CPU];
    assign bus.r1_gnt    = gnt[PORT_LDR];
    assign bus.mem_en    = granted;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    assign bus.r0_rdata  = r0_rdata_q;
    assign bus.r1_rdata  = r1_rdata_q;

    // After a read issue the FSM sits in RD_WAIT for RD_LAT cycles; lat_cnt
    // reaches zero in the cycle mem_rdata is valid (immediately for RD_LAT=1).
    // Capture and the rvalid pulse are registered, so the pulse lands in the
    // following RD_RESP cycle together with the new rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            owner       <= 1'b0;
            lat_cnt     <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;

            if (granted) begin
                last_gnt <= sel_ldr;
            end

            case (state)
                RD_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        if (owner) begin
                            r1_rdata_q  <= bus.mem_rdata;
                            r1_rvalid_q <= 1'b1;
                        end else begin
                            r0_rdata_q  <= bus.mem_rdata;
                            r0_rvalid_q <= 1'b1;
                        end
                        state <= RD_RESP;
                    end
                end
                default: begin
                    if (rd_issue) begin
                        owner   <= sel_ldr;
                        lat_cnt <= LAT_LOAD;
                        state   <= RD_WAIT;
                    end else begin
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at RD_LAT 1, 2 and 3
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b1;
    logic        mem_init = 1'b1;
    logic        r0_req   = 1'b0;
    logic        r0_we    = 1'b0;
    logic [31:0] r0_addr  = '0;
    logic [31:0] r0_wdata = '0;
    logic        r1_req   = 1'b0;
    logic        r1_we    = 1'b0;
    logic [31:0] r1_addr  = '0;
    logic [31:0] r1_wdata = '0;

    logic        o_g0  [1:3];
    logic        o_g1  [1:3];
    logic        o_en  [1:3];
    logic        o_we  [1:3];
    logic        o_rv0 [1:3];
    logic        o_rv1 [1:3];
    logic [31:0] o_addr  [1:3];
    logic [31:0] o_wdata [1:3];
    logic [31:0] o_rd0   [1:3];
    logic [31:0] o_rd1   [1:3];

    // One DUT per read latency, all fed from the same requester signals
    genvar g;
    generate
        for (g = 1; g <= 3; g++) begin : lane
            dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
            logic [31:0] mem  [0:255];
            logic [31:0] pipe [0:3];

            dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            assign bus.r0_req   = r0_req;
            assign bus.r0_we    = r0_we;
            assign bus.r0_addr  = r0_addr;
            assign bus.r0_wdata = r0_wdata;
            assign bus.r1_req   = r1_req;
            assign bus.r1_we    = r1_we;
            assign bus.r1_addr  = r1_addr;
            assign bus.r1_wdata = r1_wdata;
            assign bus.mem_rdata = pipe[g-1];

            always_ff @(posedge clk) begin
                if (mem_init) begin
                    for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 3);
                end else if (bus.mem_en && bus.mem_we) begin
                    mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
                end
                pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : 32'hDEAD_BEEF;
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end

            assign o_g0[g]    = bus.r0_gnt;
            assign o_g1[g]    = bus.r1_gnt;
            assign o_en[g]    = bus.mem_en;
            assign o_we[g]    = bus.mem_we;
            assign o_addr[g]  = bus.mem_addr;
            assign o_wdata[g] = bus.mem_wdata;
            assign o_rv0[g]   = bus.r0_rvalid;
            assign o_rv1[g]   = bus.r1_rvalid;
            assign o_rd0[g]   = bus.r0_rdata;
            assign o_rd1[g]   = bus.r1_rdata;
        end
    endgenerate

    int total = 0;
    int bad   = 0;
    int sel   = 1;

    typedef struct {
        logic        q0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        q1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [1:0]  gnt;   // {r1_gnt, r0_gnt}
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;
    vec_t tv [8];

    // reference model state
    int          m_busy;
    int          m_last;
    int          m_due  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_hold [2];
    logic [31:0] m_mem  [256];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (lane %0d): got %h want %h", nm, sel, act, exp);
        end
    endtask

    function automatic logic [133:0] snap();
        return {o_g0[sel], o_g1[sel], o_en[sel], o_we[sel], o_addr[sel], o_wdata[sel],
                o_rv0[sel], o_rv1[sel], o_rd0[sel], o_rd1[sel]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1; mem_init = 1;
        clear_in();
        r0_req = 1; r1_req = 1; r0_we = 1;
        @(negedge clk);
        chk("rst_no_gnt", {o_g1[sel], o_g0[sel], o_en[sel]}, '0);
        tick();
        @(negedge clk);
        chk("rst_values", {o_rv0[sel], o_rv1[sel], o_rd0[sel], o_rd1[sel]}, '0);
        tick();
        rst = 0; mem_init = 0;
        clear_in();
    endtask

    task automatic do_read(input int p, input logic [31:0] a, input logic [31:0] exp, input int lat);
        if (p == 0) begin r0_req = 1; r0_we = 0; r0_addr = a; end
        else        begin r1_req = 1; r1_we = 0; r1_addr = a; end
        @(negedge clk);
        chk("rd_gnt", (p == 0) ? o_g0[sel] : o_g1[sel], 1'b1);
        tick();
        if (p == 0) r0_req = 0; else r1_req = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            chk("rd_valid", (p == 0) ? o_rv0[sel] : o_rv1[sel], (k == lat + 1));
            if (k == lat + 1) chk("rd_data", (p == 0) ? o_rd0[sel] : o_rd1[sel], exp);
            tick();
        end
    endtask

    task automatic new_req(output logic we, output logic [31:0] a, output logic [31:0] d);
        we = ($urandom_range(0, 1) == 1);
        a  = 32'($urandom_range(0, 15));
        d  = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, n1;

        tv[0] = '{1'b1, 32'h10, 32'hAAAA0000, 1'b1, 32'h20, 32'h5555FFFF, 2'b01, 32'h10, 32'hAAAA0000};
        tv[1] = '{1'b0, 32'h10, 32'hAAAA0000, 1'b1, 32'h20, 32'h5555FFFF, 2'b10, 32'h20, 32'h5555FFFF};
        tv[2] = '{1'b0, 32'h99, 32'h00001234, 1'b0, 32'h98, 32'h00005678, 2'b00, 32'h00, 32'h00000000};
        tv[3] = '{1'b1, 32'h30, 32'h00000011, 1'b0, 32'h98, 32'h00005678, 2'b01, 32'h30, 32'h00000011};
        tv[4] = '{1'b1, 32'h34, 32'h00000022, 1'b0, 32'h98, 32'h00005678, 2'b01, 32'h34, 32'h00000022};
        tv[5] = '{1'b1, 32'h38, 32'h00000033, 1'b1, 32'h40, 32'h00000044, 2'b10, 32'h40, 32'h00000044};
        tv[6] = '{1'b1, 32'h38, 32'h00000033, 1'b1, 32'h44, 32'h00000055, 2'b01, 32'h38, 32'h00000033};
        tv[7] = '{1'b0, 32'h38, 32'h00000033, 1'b1, 32'h44, 32'h00000055, 2'b10, 32'h44, 32'h00000055};

        // ---- write arbitration table (RD_LAT=2 lane)
        sel = 2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r0_req = tv[i].q0; r0_we = 1; r0_addr = tv[i].a0; r0_wdata = tv[i].d0;
            r1_req = tv[i].q1; r1_we = 1; r1_addr = tv[i].a1; r1_wdata = tv[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {o_g1[sel], o_g0[sel], o_en[sel], o_we[sel], o_addr[sel], o_wdata[sel]},
                {tv[i].gnt, |tv[i].gnt, |tv[i].gnt, tv[i].addr, tv[i].wdata});
            tick();
        end
        clear_in();

        // ---- both ports write continuously for 8 cycles
        n0 = 0; n1 = 0;
        r0_req = 1; r0_we = 1; r0_addr = 32'h50; r0_wdata = 32'h5;
        r1_req = 1; r1_we = 1; r1_addr = 32'h60; r1_wdata = 32'h6;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("alternate", {o_g1[sel], o_g0[sel]}, (k % 2 == 0) ? 2'b01 : 2'b10);
            n0 += int'(o_g0[sel]);
            n1 += int'(o_g1[sel]);
            tick();
        end
        clear_in();
        chk("alt_counts", {n0, n1}, {32'd4, 32'd4});

        // ---- RD_LAT=2 read by port 0 while port 1 waits
        do_read(1, 32'h20, 32'h5555FFFF, 2);
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        r1_req = 1; r1_we = 1; r1_addr = 32'h70; r1_wdata = 32'h77;
        @(negedge clk);
        chk("b_issue", {o_g1[sel], o_g0[sel], o_en[sel], o_we[sel], o_addr[sel]},
            {2'b01, 1'b1, 1'b0, 32'h10});
        tick();
        r0_req = 0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("b_wait", {o_g1[sel], o_g0[sel], o_en[sel], o_rv0[sel]}, '0);
            tick();
        end
        @(negedge clk);
        chk("b_resp", {o_rv0[sel], o_rd0[sel], o_rd1[sel], o_g1[sel], o_g0[sel], o_we[sel], o_addr[sel]},
            {1'b1, 32'hAAAA0000, 32'h5555FFFF, 1'b1, 1'b0, 1'b1, 32'h70});
        tick();
        r1_req = 0;
        @(negedge clk);
        chk("b_single_pulse", o_rv0[sel], 1'b0);
        tick();

        // ---- reset in the middle of an RD_LAT=3 read by port 1
        sel = 3;
        do_reset();
        r1_req = 1; r1_we = 0; r1_addr = 32'h5;
        @(negedge clk);
        chk("d_gnt", o_g1[sel], 1'b1);
        tick();
        r1_req = 0; rst = 1;
        @(negedge clk);
        chk("d_rst_gnt", {o_g0[sel], o_g1[sel], o_en[sel]}, '0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("d_reset_outs", snap(), '0);
        tick();
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            chk("d_no_rvalid", o_rv1[sel], 1'b0);
            tick();
        end
        do_read(0, 32'h7, 32'd21, 3);

        // ---- port 0 pulses a request while RD_WAIT is active
        r1_req = 1; r1_we = 0; r1_addr = 32'h2;
        @(negedge clk);
        chk("f_gnt", o_g1[sel], 1'b1);
        tick();
        r1_req = 0; r0_req = 1; r0_we = 0; r0_addr = 32'h9;
        @(negedge clk);
        chk("f_pulse", {o_g0[sel], o_en[sel]}, '0);
        tick();
        r0_req = 0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("f_quiet", {o_g0[sel], o_en[sel], o_rv0[sel], o_rv1[sel]}, {3'b000, (k == 4)});
            tick();
        end

        // ---- RD_LAT=1 sweep: both ports read continuously
        sel = 1;
        do_reset();
        begin
            int idx0, idx1, due0, due1, c;
            logic [31:0] ex0, ex1;
            idx0 = 0; idx1 = 0; due0 = -1; due1 = -1; ex0 = '0; ex1 = '0;
            r0_req = 1; r0_we = 0; r0_addr = 32'd8;
            r1_req = 1; r1_we = 0; r1_addr = 32'd0;
            for (c = 0; c < 60 && (idx0 < 8 || idx1 < 8 || due0 >= c || due1 >= c); c++) begin
                @(negedge clk);
                chk("e_rv0", o_rv0[sel], (c == due0));
                chk("e_rv1", o_rv1[sel], (c == due1));
                if (c == due0) chk("e_rd0", o_rd0[sel], ex0);
                if (c == due1) chk("e_rd1", o_rd1[sel], ex1);
                if ((c == due0 || c == due1) && (idx0 < 8 || idx1 < 8))
                    chk("e_back_to_back", o_en[sel], 1'b1);
                if (o_g0[sel]) begin due0 = c + 2; ex0 = 32'(3 * (8 + idx0)); idx0++; end
                if (o_g1[sel]) begin due1 = c + 2; ex1 = 32'(3 * idx1); idx1++; end
                tick();
                r0_req = (idx0 < 8); r0_addr = 32'(8 + idx0);
                r1_req = (idx1 < 8); r1_addr = 32'(idx1);
            end
            chk("e_all_done", {idx0, idx1}, {32'd8, 32'd8});
            clear_in();
        end

        // ---- randomized traffic against the reference model, every lane
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            do_reset();
            m_busy = 0; m_last = 1; m_due[0] = -1; m_due[1] = -1;
            m_hold[0] = '0; m_hold[1] = '0; m_pend[0] = '0; m_pend[1] = '0;
            for (int i = 0; i < 256; i++) m_mem[i] = 32'(i * 3);
            for (int c = 0; c < 300; c++) begin
                int w;
                logic got0, got1, wwe;
                logic [31:0] wa, wd;
                logic [133:0] exp;
                @(negedge clk);
                w = -1;
                if (m_busy == 0) begin
                    if (r0_req && r1_req) w = 1 - m_last;
                    else if (r0_req)      w = 0;
                    else if (r1_req)      w = 1;
                end
                wwe = (w == 0) ? r0_we : (w == 1) ? r1_we : 1'b0;
                wa  = (w == 0) ? r0_addr : (w == 1) ? r1_addr : 32'h0;
                wd  = (w == 0) ? r0_wdata : (w == 1) ? r1_wdata : 32'h0;
                for (int p = 0; p < 2; p++) if (m_due[p] == c) m_hold[p] = m_pend[p];
                exp = {(w == 0), (w == 1), (w >= 0), wwe, wa, wd,
                       (m_due[0] == c), (m_due[1] == c), m_hold[0], m_hold[1]};
                chk("model", snap(), exp);
                if (m_busy > 0) m_busy--;
                if (w >= 0) begin
                    m_last = w;
                    if (wwe) m_mem[wa[7:0]] = wd;
                    else begin
                        m_busy   = s;
                        m_due[w] = c + s + 1;
                        m_pend[w] = m_mem[wa[7:0]];
                    end
                end
                got0 = o_g0[sel];
                got1 = o_g1[sel];
                tick();
                if (got0 ? ($urandom_range(0, 1) == 1) : (!r0_req && $urandom_range(0, 2) == 0)) begin
                    r0_req = 1; new_req(r0_we, r0_addr, r0_wdata);
                end else if (got0 || $urandom_range(0, 15) == 0) r0_req = 0;
                if (got1 ? ($urandom_range(0, 1) == 1) : (!r1_req && $urandom_range(0, 2) == 0)) begin
                    r1_req = 1; new_req(r1_we, r1_addr, r1_wdata);
                end else if (got1 || $urandom_range(0, 15) == 0) r1_req = 0;
            end
            clear_in();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
